// File: rtl/aibcr3pnr_dll_lock_fsm_pkg.sv
// Shared definitions for the DLL lock controller: state encoding,
// default parameter values and phase-detector direction constants.
package aibcr3pnr_dll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_STEP   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_ERR    = 3'd5,
    ST_OVRD   = 3'd6
  } dll_state_e;

  localparam int DEF_CODE_W     = 10;
  localparam int DEF_CODE_INIT  = 512;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_LOSS_CNT   = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Reversal counter saturates instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/aibcr3pnr_dll_lock_fsm_if.sv
// Control/observe bundle between the DLL lock controller and its environment.
// The master drives PD and register bits; the slave returns code and status.
interface aibcr3pnr_dll_lock_fsm_if
  import aibcr3pnr_dll_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W
);

  logic              pd_up;
  logic              track_en;
  logic              rb_code_ovrd_en;
  logic [CODE_W-1:0] rb_code_ovrd;
  logic [CODE_W-1:0] dll_code;
  logic              dll_lock;
  logic              dll_err;
  logic [2:0]        dll_state;

  modport master (
    output pd_up, track_en, rb_code_ovrd_en, rb_code_ovrd,
    input  dll_code, dll_lock, dll_err, dll_state
  );

  modport slave (
    input  pd_up, track_en, rb_code_ovrd_en, rb_code_ovrd,
    output dll_code, dll_lock, dll_err, dll_state
  );

endinterface

// File: rtl/aibcr3pnr_dll_lock_fsm.sv
// DLL delay-code acquisition/tracking controller: steps the code from PD
// samples, declares lock after sustained dithering and flags range overflow.
module aibcr3pnr_dll_lock_fsm
  import aibcr3pnr_dll_pkg::*;
#(
  parameter int CODE_W     = DEF_CODE_W,
  parameter int CODE_INIT  = DEF_CODE_INIT,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int LOSS_CNT   = DEF_LOSS_CNT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  aibcr3pnr_dll_lock_fsm_if.slave  bus
);

  localparam logic [CODE_W-1:0] CODE_RST    = CODE_W'(CODE_INIT);
  localparam logic [CODE_W-1:0] CODE_ONE    = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_MAX    = {CODE_W{1'b1}};
  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0]        LOCK_LIM    = 4'(LOCK_CNT);
  localparam logic [3:0]        LOSS_LIM    = 4'(LOSS_CNT);

  dll_state_e        state_q, state_d;
  logic [7:0]        settle_q, settle_d;
  logic              dir_n_q, dir_n_d;
  logic              prev_dir_q, prev_dir_d;
  logic              prev_vld_q, prev_vld_d;
  logic [3:0]        rev_q, rev_d;
  logic [3:0]        loss_q, loss_d;
  logic              trk_q, trk_d;
  logic [CODE_W-1:0] code_q, code_d, acq_code_d;
  logic              lock_q, lock_d;
  logic              err_q, err_d;

  logic              hit_bound;
  logic              is_rev;
  logic [3:0]        rev_upd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      dir_n_q    <= DIR_DN;
      prev_dir_q <= DIR_DN;
      prev_vld_q <= 1'b0;
      rev_q      <= '0;
      loss_q     <= '0;
      trk_q      <= 1'b0;
      code_q     <= CODE_RST;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      dir_n_q    <= dir_n_d;
      prev_dir_q <= prev_dir_d;
      prev_vld_q <= prev_vld_d;
      rev_q      <= rev_d;
      loss_q     <= loss_d;
      trk_q      <= trk_d;
      code_q     <= code_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    dir_n_d    = dir_n_q;
    prev_dir_d = prev_dir_q;
    prev_vld_d = prev_vld_q;
    rev_d      = rev_q;
    loss_d     = loss_q;
    trk_d      = trk_q;
    lock_d     = lock_q;
    err_d      = err_q;
    acq_code_d = code_q;
    hit_bound  = 1'b0;
    is_rev     = 1'b0;
    rev_upd    = 4'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.rb_code_ovrd_en) begin
          state_d = ST_OVRD;
        end else begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end

      ST_SAMPLE: begin
        dir_n_d = bus.pd_up;
        state_d = ST_STEP;
      end

      // Range check wins over both the lock decision and lock loss.
      ST_STEP: begin
        hit_bound = (dir_n_q == DIR_UP) ? (code_q == CODE_MAX) : (code_q == '0);
        is_rev    = prev_vld_q && (dir_n_q != prev_dir_q);
        rev_upd   = is_rev ? sat_inc4(rev_q) : 4'd0;
        if (hit_bound) begin
          state_d = ST_ERR;
          lock_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          acq_code_d = (dir_n_q == DIR_UP) ? code_q + CODE_ONE : code_q - CODE_ONE;
          prev_dir_d = dir_n_q;
          prev_vld_d = 1'b1;
          rev_d      = rev_upd;
          settle_d   = '0;
          if (trk_q) begin
            if (is_rev) begin
              loss_d  = '0;
              state_d = ST_LOCKED;
            end else if (loss_q + 4'd1 == LOSS_LIM) begin
              // Lost lock: restart acquisition from the current code.
              lock_d     = 1'b0;
              rev_d      = '0;
              loss_d     = '0;
              prev_vld_d = 1'b0;
              trk_d      = 1'b0;
              state_d    = ST_SETTLE;
            end else begin
              loss_d  = loss_q + 4'd1;
              state_d = ST_LOCKED;
            end
          end else if (rev_upd == LOCK_LIM) begin
            state_d = ST_LOCKED;
            lock_d  = 1'b1;
            loss_d  = '0;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end

      ST_LOCKED: begin
        if (bus.track_en) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          trk_d    = 1'b1;
        end
      end

      ST_ERR: begin
        lock_d = 1'b0;
      end

      ST_OVRD: begin
        lock_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign code_d = (state_q == ST_OVRD) ? bus.rb_code_ovrd : acq_code_d;

  assign bus.dll_code  = code_q;
  assign bus.dll_lock  = lock_q;
  assign bus.dll_err   = err_q;
  assign bus.dll_state = state_q;

endmodule
